inst_encoder: RTL

//   Builds RISC-V RV32 instruction words from decoded fields (format, opcode,

---
 rtl/inst_encoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32 instruction word builder (I/S/B/U/J formats plus the li pseudo-op), valid/ready in and out.
// Optional immediate range checking and the out_err port are enabled by defining IMM_RANGE_CHECK_EN.
module inst_encoder #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic        in_li,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic        out_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_SECOND
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_inst;
    logic        r_last;
    logic        r_pend;
    logic [31:0] r_second;

    logic        w_accept;
    logic        w_take;
    logic [11:0] w_lo;
    logic [19:0] w_hi;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic [31:0] w_addi_x0;
    logic [31:0] w_lui;
    logic [31:0] w_addi_rd;
    logic [31:0] w_first;
    logic        w_pend;

    assign w_accept = in_valid & in_ready;
    assign w_take   = out_valid & out_ready;

    // (imm + 0x800) >> 12 mod 2^32 is the upper 20 bits plus the carry in from imm[11].
    assign w_lo      = in_imm[11:0];
    assign w_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
    assign w_fits12  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fits13  = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fits21  = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign w_addi_x0 = {w_lo, 5'd0, 3'b000, in_rd, 7'h13};
    assign w_lui     = {w_hi, in_rd, 7'h37};
    assign w_addi_rd = {w_lo, in_rd, 3'b000, in_rd, 7'h13};

    always_comb begin
        w_first = NOP_INST;
        w_pend  = 1'b0;
        if (in_li) begin
            if (w_fits12) begin
                w_first = w_addi_x0;
            end else if (w_lo == 12'd0) begin
                w_first = w_lui;
            end else begin
                w_first = w_lui;
                w_pend  = 1'b1;
            end
        end else begin
            case (in_fmt)
                3'd0: w_first = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                3'd1: w_first = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                3'd2: w_first = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
                3'd3: w_first = {in_imm[31:12], in_rd, in_opcode};
                3'd4: w_first = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
                default: w_first = NOP_INST;
            endcase
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic r_err;
    logic w_err;

    always_comb begin
        w_err = 1'b0;
        if (!in_li) begin
            case (in_fmt)
                3'd0, 3'd1: w_err = ~w_fits12;
                3'd2:       w_err = ~w_fits13 | in_imm[0];
                3'd3:       w_err = |in_imm[11:0];
                3'd4:       w_err = ~w_fits21 | in_imm[0];
                default:    w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_err;
        end else if (r_state == S_EMIT && w_take && r_pend) begin
            r_err <= 1'b0;
        end
    end

    assign out_err = r_err;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_inst   <= '0;
            r_last   <= 1'b0;
            r_pend   <= 1'b0;
            r_second <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_inst   <= w_first;
                r_last   <= ~w_pend;
                r_pend   <= w_pend;
                r_second <= w_addi_rd;
            end else if (r_state == S_EMIT && w_take && r_pend) begin
                r_inst <= r_second;
                r_last <= 1'b1;
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_state_next = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (w_take) w_state_next = r_pend ? S_SECOND : S_IDLE;
            end
            S_SECOND: begin
                out_valid = 1'b1;
                if (w_take) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign out_inst = r_inst;
    assign out_last = r_last;

endmodule
